// File: rtl/temp_scan_display.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : temp_scan_display
// Brief    : Sensor word to BCD (double-dabble), hysteretic cold/normal/hot
//            class, and time-multiplexed common-anode 7-segment scan.
// Revision : 1.0 - initial release
// ============================================================================
module temp_scan_display #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int INT_W    = 6,
  parameter int LO_TH    = 65,
  parameter int HI_TH    = 71,
  parameter int HYST     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         data,
  input  logic                data_valid,
  output logic                ready,
  output logic                conv_done,
  output logic [11:0]         int_bcd,
  output logic                frac5,
  output logic [1:0]          cls,
  output logic [7:0]          seg,
  output logic [N_DIGITS-1:0] cs
);

  localparam int CNT_W  = $clog2(INT_W + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(INT_W - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

  localparam logic [31:0] HI_C  = 32'(HI_TH);
  localparam logic [31:0] LO_C  = 32'(LO_TH);
  localparam logic [31:0] HI_HC = 32'(HI_TH - HYST);
  localparam logic [31:0] LO_HC = 32'(LO_TH - HYST);

  localparam logic [1:0] CLS_COLD = 2'd0;
  localparam logic [1:0] CLS_NORM = 2'd1;
  localparam logic [1:0] CLS_HOT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [INT_W-1:0]    sh_q, sh_d;
  logic [INT_W-1:0]    raw_q, raw_d;
  logic                half_q, half_d;
  logic [11:0]         bcd_q, bcd_d;
  logic [11:0]         int_bcd_q, int_bcd_d;
  logic                frac5_q, frac5_d;
  logic [1:0]          cls_q, cls_d;
  logic                done_q, done_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [11:0]         w_adj;
  logic [31:0]         w_t;
  logic [1:0]          w_cls_new;
  logic [7:0]          w_idx;
  logic                w_unused;

  function automatic logic [11:0] dd_adj(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int k = 0; k < 3; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hc0;
      4'd1:    return 8'hf9;
      4'd2:    return 8'ha4;
      4'd3:    return 8'hb0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hf8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hff;
    endcase
  endfunction

  assign w_adj    = dd_adj(bcd_q);
  assign w_t      = 32'({raw_q, half_q});
  assign w_unused = ^{data[15:8], data[6:0], w_adj[11]};

  always_comb begin
    w_cls_new = cls_q;
    case (cls_q)
      CLS_COLD: begin
        if (w_t >= HI_C)      w_cls_new = CLS_HOT;
        else if (w_t >= LO_C) w_cls_new = CLS_NORM;
      end
      CLS_NORM: begin
        if (w_t >= HI_C)       w_cls_new = CLS_HOT;
        else if (w_t < LO_HC)  w_cls_new = CLS_COLD;
      end
      CLS_HOT: begin
        if (w_t < LO_HC)       w_cls_new = CLS_COLD;
        else if (w_t < HI_HC)  w_cls_new = CLS_NORM;
      end
      default: w_cls_new = CLS_COLD;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    raw_d     = raw_q;
    half_d    = half_q;
    bcd_d     = bcd_q;
    int_bcd_d = int_bcd_q;
    frac5_d   = frac5_q;
    cls_d     = cls_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          sh_d    = data[8 +: INT_W];
          raw_d   = data[8 +: INT_W];
          half_d  = data[7];
          bcd_d   = 12'd0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // add-3 correction first, then shift the next binary MSB into the BCD LSB
        bcd_d = {w_adj[10:0], sh_q[INT_W-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        int_bcd_d = bcd_q;
        frac5_d   = half_q;
        cls_d     = w_cls_new;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      raw_q     <= '0;
      half_q    <= 1'b0;
      bcd_q     <= 12'd0;
      int_bcd_q <= 12'd0;
      frac5_q   <= 1'b0;
      cls_q     <= CLS_COLD;
      done_q    <= 1'b0;
      scan_q    <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      raw_q     <= raw_d;
      half_q    <= half_d;
      bcd_q     <= bcd_d;
      int_bcd_q <= int_bcd_d;
      frac5_q   <= frac5_d;
      cls_q     <= cls_d;
      done_q    <= done_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign conv_done = done_q;
  assign int_bcd   = int_bcd_q;
  assign frac5     = frac5_q;
  assign cls       = cls_q;

  assign w_idx = 8'(idx_q);

  // Decoded only from registers so the display never sees in-flight BCD.
  always_comb begin
    seg = 8'hff;
    case (w_idx)
      8'd0: seg = frac5_q ? 8'h92 : 8'hc0;
      8'd1: seg = glyph(int_bcd_q[3:0]) & 8'h7f;
      8'd2: seg = (int_bcd_q[11:4] == 8'h00) ? 8'hff : glyph(int_bcd_q[7:4]);
      8'd3: seg = (int_bcd_q[11:8] == 4'h0) ? 8'hff : glyph(int_bcd_q[11:8]);
      8'd4: begin
        case (cls_q)
          CLS_COLD: seg = 8'hc6;
          CLS_NORM: seg = 8'hab;
          CLS_HOT:  seg = 8'h89;
          default:  seg = 8'hff;
        endcase
      end
      default: seg = 8'hff;
    endcase
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_cs
    assign cs[i] = (w_idx != 8'(i));
  end

endmodule
`default_nettype wire

// File: tb/tb_temp_scan_display.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_temp_scan_display
// Brief    : Self-checking bench for temp_scan_display (table + random + corners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_temp_scan_display;

  localparam int N  = 5;
  localparam int SD = 4;
  localparam int IW = 8;
  localparam int LO = 65;
  localparam int HI = 71;
  localparam int HY = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  data;
  logic         data_valid;
  logic         ready;
  logic         conv_done;
  logic [11:0]  int_bcd;
  logic         frac5;
  logic [1:0]   cls;
  logic [7:0]   seg;
  logic [N-1:0] cs;

  temp_scan_display #(
    .N_DIGITS(N), .SCAN_DIV(SD), .INT_W(IW), .LO_TH(LO), .HI_TH(HI), .HYST(HY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .ready(ready), .conv_done(conv_done), .int_bcd(int_bcd), .frac5(frac5),
    .cls(cls), .seg(seg), .cs(cs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [11:0] m_bcd;
  logic        m_frac;
  logic [1:0]  m_cls;
  logic [7:0]  glyph [0:9] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99,
                               8'h92, 8'h82, 8'hf8, 8'h80, 8'h90};

  typedef struct {
    logic [15:0] d;
    logic [11:0] bcd;
    logic        frac;
    logic [1:0]  cl;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bcd  = 12'h000;
    m_frac = 1'b0;
    m_cls  = 2'd0;
  endtask

  // Reference: plain decimal arithmetic and the class rules as stated.
  task automatic model_commit(input logic [15:0] d);
    int v, t;
    v = int'(d[15:8]);
    t = v * 2 + int'(d[7]);
    m_bcd  = 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    m_frac = d[7];
    case (m_cls)
      2'd0: if (t >= HI) m_cls = 2'd2; else if (t >= LO) m_cls = 2'd1;
      2'd1: if (t >= HI) m_cls = 2'd2; else if (t < LO - HY) m_cls = 2'd0;
      2'd2: if (t < LO - HY) m_cls = 2'd0; else if (t < HI - HY) m_cls = 2'd1;
      default: m_cls = 2'd0;
    endcase
  endtask

  function automatic logic [7:0] exp_seg(input int idx);
    int h, t, u;
    h = int'(m_bcd[11:8]);
    t = int'(m_bcd[7:4]);
    u = int'(m_bcd[3:0]);
    case (idx)
      0: return m_frac ? 8'h92 : 8'hc0;
      1: return glyph[u] & 8'h7f;
      2: return (h == 0 && t == 0) ? 8'hff : glyph[t];
      3: return (h == 0) ? 8'hff : glyph[h];
      4: return (m_cls == 2'd0) ? 8'hc6 : (m_cls == 2'd1) ? 8'hab : 8'h89;
      default: return 8'hff;
    endcase
  endfunction

  task automatic wait_ready();
    int g;
    g = 0;
    while (!ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!ready) check("ready_wait", 32'(ready), 32'd1);
  endtask

  // Offer d for one edge, then drive alt (with valid for `extra` further edges).
  task automatic conv_check(input string tag, input logic [15:0] d,
                            input logic [15:0] alt, input int extra);
    int lat, nlow, ndone;
    wait_ready();
    data = d;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data = alt;
    lat = -1; nlow = 0; ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      data_valid = (i < extra);
      if (!ready) nlow++;
      if (conv_done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      if (lat >= 0 && i >= lat + 2) break;
    end
    data_valid = 1'b0;
    model_commit(d);
    check({tag, ".latency"}, lat, IW + 1);
    check({tag, ".ready_low"}, nlow, IW + 1);
    check({tag, ".done_count"}, ndone, 1);
    check({tag, ".int_bcd"}, 32'(int_bcd), 32'(m_bcd));
    check({tag, ".frac5"}, 32'(frac5), 32'(m_frac));
    check({tag, ".cls"}, 32'(cls), 32'(m_cls));
  endtask

  task automatic scan_check(input string tag);
    logic [N-1:0] prev, e;
    logic found;
    int idx;
    found = 1'b0;
    prev = cs;
    for (int i = 0; i < 2 * SD * N + 2 && !found; i++) begin
      @(posedge clk); #1;
      if (cs == 5'b11110 && prev == 5'b01111) found = 1'b1;
      prev = cs;
    end
    check({tag, ".scan_sync"}, 32'(found), 32'd1);
    for (int k = 0; k <= SD * N; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      idx = (k / SD) % N;
      e = '1;
      e[idx] = 1'b0;
      check({tag, ".cs"}, 32'(cs), 32'(e));
      check({tag, ".seg"}, 32'(seg), 32'(exp_seg(idx)));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".ready"}, 32'(ready), 32'd1);
    check({tag, ".conv_done"}, 32'(conv_done), 32'd0);
    check({tag, ".int_bcd"}, 32'(int_bcd), 32'd0);
    check({tag, ".frac5"}, 32'(frac5), 32'd0);
    check({tag, ".cls"}, 32'(cls), 32'd0);
    check({tag, ".cs"}, 32'(cs), 32'(5'b11110));
    check({tag, ".seg"}, 32'(seg), 32'h0c0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [15:0] d;
    tbl[0] = '{16'h2180, 12'h033, 1'b1, 2'd1};
    tbl[1] = '{16'h2380, 12'h035, 1'b1, 2'd2};
    tbl[2] = '{16'h2300, 12'h035, 1'b0, 2'd2};
    tbl[3] = '{16'h2280, 12'h034, 1'b1, 2'd1};
    tbl[4] = '{16'h2000, 12'h032, 1'b0, 2'd1};
    tbl[5] = '{16'h1F80, 12'h031, 1'b1, 2'd0};

    rst_n = 1'b0;
    data = 16'h0;
    data_valid = 1'b0;
    model_reset();
    #3;
    check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold.cs", 32'(cs), 32'(5'b11110));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      conv_check($sformatf("vec%0d", i), tbl[i].d, ~tbl[i].d, 0);
      check($sformatf("vec%0d.tbl_bcd", i), 32'(int_bcd), 32'(tbl[i].bcd));
      check($sformatf("vec%0d.tbl_frac", i), 32'(frac5), 32'(tbl[i].frac));
      check($sformatf("vec%0d.tbl_cls", i), 32'(cls), 32'(tbl[i].cl));
      scan_check($sformatf("vec%0d", i));
    end

    conv_check("busy", 16'h1400, 16'h3F00, 3);
    check("busy.tbl_bcd", 32'(int_bcd), 32'h020);

    wait_ready();
    data = 16'h5A80;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_vals("midrst");
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (conv_done) ndone++;
    end
    check("midrst.no_done", ndone, 0);
    check("midrst.int_bcd_after", 32'(int_bcd), 32'd0);
    conv_check("fresh", 16'h2480, 16'h0000, 0);
    scan_check("fresh");

    for (int r = 0; r < 40; r++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) d[15:8] = 8'($urandom_range(28, 40));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      conv_check($sformatf("rnd%0d", r), d, 16'($urandom), $urandom_range(0, 4));
      if (r % 10 == 9) scan_check($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/temp_scan_display.md
# temp_scan_display

Parametrised temperature display engine for the sensor front end. It accepts a 16-bit sensor word on a valid/ready handshake and converts the integer field to BCD iteratively using double-dabble. It classifies the reading as cold, normal or hot with hysteresis, and time-multiplexes the result onto an N-digit common-anode 7-segment display. It sits between the sensor-read block and the board display/LCD selector.

## Interface
- `N_DIGITS`, 4: scanned digits, legal range 2..8.
- `SCAN_DIV`, 50000: clk cycles per digit slot, minimum 2.
- `INT_W`, 6: integer field width, taken from `data[8+INT_W-1:8]`; legal range 1..8.
- `LO_TH`, 65: cold→normal threshold in half-degree units (32.5).
- `HI_TH`, 71: normal→hot threshold in half-degree units (35.5).
- `HYST`, 1: hysteresis in half-degree units.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data` in 16: sensor word; `data[7]` is the half-degree bit.
- `data_valid` in 1: word offered.
- `ready` out 1: engine idle and able to accept.
- `conv_done` out 1: one-cycle pulse when a new result is committed.
- `int_bcd` out 12: committed integer as hundreds/tens/units BCD, `[11:8]/[7:4]/[3:0]`.
- `frac5` out 1: committed half-degree bit.
- `cls` out 2: committed class; 0 cold, 1 normal, 2 hot. Value 3 never occurs.
- `seg` out 8: active-low segments, `seg[7]` = decimal point.
- `cs` out N_DIGITS: active-low one-hot digit select.

## Operation
- Handshake: a word is accepted on an edge where `data_valid && ready`. `data` is sampled at that edge; later changes are ignored. `data_valid` while `ready` = 0 is ignored and not queued.
- States: IDLE → CONV (INT_W cycles, one double-dabble shift/add-3 per cycle) → COMMIT (1 cycle) → IDLE.
- COMMIT updates `int_bcd`, `frac5` and `cls` atomically and pulses `conv_done`.
- Temperature value is `t = {int, data[7]}`, INT_W+1 bits, unsigned.
- Class transitions are evaluated at COMMIT on the new `t`:
  - COLD → HOT if `t ≥ HI_TH`; otherwise COLD → NORMAL if `t ≥ LO_TH`.
  - NORMAL → HOT if `t ≥ HI_TH`; NORMAL → COLD if `t < LO_TH-HYST`.
  - HOT → COLD if `t < LO_TH-HYST`; otherwise HOT → NORMAL if `t < HI_TH-HYST`.
  - Any other case holds the current class.
- Scan: a counter runs 0..SCAN_DIV-1. At SCAN_DIV-1 the digit index advances, wrapping from N_DIGITS-1 to 0. `cs[i]` = 0 iff index == i. There is no all-off slot.
- Digit content by index:
  - 0: fraction, showing 5 or 0.
  - 1: units, with decimal point lit.
  - 2: tens.
  - 3: hundreds.
  - 4: class glyph.
  - ≥5: blank.
- Leading-zero blanking: hundreds is blank when 0; tens is blank when hundreds and tens are both 0. Units are always shown.
- Glyphs are active-low:
  - Digits: 0=c0, 1=f9, 2=a4, 3=b0, 4=99, 5=92, 6=82, 7=f8, 8=80, 9=90.
  - Class: C=c6, n=ab, H=89.
  - Blank = ff.
  - Decimal point clears bit 7.
- `seg` and `cs` are decoded only from registered state (index plus committed values), so they are glitch-free. The display shows committed values only, never in-flight conversion values.

## Timing
- Reset values: `ready`=1, `conv_done`=0, `int_bcd`=0, `frac5`=0, `cls`=0, scan index 0, scan counter 0, `cs`=~1 (bit 0 low), `seg`=c0.
- Acceptance at edge E0 drops `ready` after E0.
- Shifts occur at E1..E_INT_W. COMMIT occurs at E_INT_W+1: outputs update, `conv_done`=1 for one cycle, `ready`=1.
- `ready` is low for exactly INT_W+1 cycles. The earliest next acceptance is E_INT_W+2.
- Digit index changes on the edge where the counter equals SCAN_DIV-1. Each digit is selected for exactly SCAN_DIV cycles.
- A COMMIT landing mid-slot changes `seg` from the next cycle; `cs` is unaffected.
- `rst_n` asserted at any time, including mid-CONV, aborts the conversion immediately (asynchronously) and restores all reset values. No `conv_done` is produced for the aborted word.

## Test plan
- Reset: hold `rst_n`=0 → `cs`=4'b1110, `seg`=c0, `ready`=1, `cls`=0, `int_bcd`=0.
- `data`=16'h2180 (33.5) with a one-cycle valid:
  - `ready` is low 7 cycles; `conv_done` pulses at E7.
  - `int_bcd`=12'h033, `frac5`=1, `cls`=1.
  - Scan: digit0=92, digit1=30, digit2=b0, digit3=ff.
- Hysteresis, in sequence:
  - 16'h2380 (35.5) → `cls`=2.
  - 16'h2300 (35.0, t=70) → `cls` stays 2.
  - 16'h2280 (34.5) → `cls`=1.
  - 16'h2000 (32.0, t=64) → `cls` stays 1.
  - 16'h1F80 (31.5) → `cls`=0.
- Busy ignore: accept 16'h1400, then assert `data_valid` with 16'h3F00 for the next 3 cycles → only 20 is committed (`int_bcd`=12'h020) and only one `conv_done` pulse occurs.
- Scan wrap with `SCAN_DIV`=4, `N_DIGITS`=5:
  - `cs` steps 11110→11101→11011→10111→01111→11110, each held 4 cycles.
  - Digit4 shows c6, ab or 89 according to `cls`.
- Reset mid-conversion: pulse `rst_n` low at E3 of a conversion → all outputs return to reset values and no `conv_done` is seen; a fresh word then converts normally.
